led_seq_ctrl: RTL
=================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 6: LED bus width, matching the LED PIO data width.
REQ-002 Parameter PRESC_W, default 24: width of the tick prescaler and PERIOD register.
REQ-003 clk  in  1  system clock, all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cfg_address  in  2  config slave register select.
REQ-006 cfg_chipselect  in  1, cfg_write_n  in  1, cfg_writedata  in  32: config slave write strobe and data.
REQ-007 cfg_readdata  out  32  combinational read of the selected register; unused bits read 0.
REQ-008 m_address  out  2, m_chipselect  out  1, m_write_n  out  1, m_writedata  out  WIDTH: master port to the LED PIO slave (zero wait states).
REQ-009 m_readdata  in  WIDTH  PIO readback, valid in the same cycle as the read strobe.
REQ-010 irq  out  1  high while any sticky STATUS error bit is set.

Function
REQ-011 Registers: 0 CTRL {bit0 EN, bits2:1 MODE, bit3 VERIFY}; 1 PERIOD[PRESC_W-1:0]; 2 PATTERN[WIDTH-1:0]; 3 STATUS {bit0 BUSY (read-only), bit1 VERR, bit2 MISS}.
REQ-012 STATUS write: writing 1 to bit1 or bit2 clears that bit; writing 0 leaves it; VERR and MISS are otherwise sticky.
REQ-013 Prescaler: counts 0..PERIOD while EN=1 and emits a 1-cycle tick on the cycle count==PERIOD, then wraps to 0; PERIOD=0 gives a tick every cycle.
REQ-014 Prescaler is held at 0 while EN=0; a PERIOD write while running takes effect on the next wrap.
REQ-015 A shadow register cur[WIDTH-1:0] holds the last pattern issued.
REQ-016 Next pattern on tick, by MODE: 00 static (next=PATTERN); 01 blink (next=cur^PATTERN); 10 chase (rotate cur left by 1, next=1 if cur==0); 11 count (next=cur+1, wraps modulo 2^WIDTH).
REQ-017 A write to PATTERN loads cur with writedata[WIDTH-1:0] and sets a pending-write flag, independent of EN.
REQ-018 FSM states: IDLE, WR, RD, CHK.
REQ-019 IDLE: a pending flag or a tick moves the FSM to WR the next cycle; pending has priority and is cleared on leaving IDLE; on a tick, cur updates on entry to WR.
REQ-020 WR (1 cycle): m_chipselect=1, m_write_n=0, m_address=0, m_writedata=cur; goes to RD if VERIFY=1, else to IDLE.
REQ-021 RD (1 cycle): m_chipselect=1, m_write_n=1, m_address=0; m_readdata is captured at the end of the cycle; goes to CHK.
REQ-022 CHK (1 cycle): if the captured value != cur, set VERR; goes to IDLE.
REQ-023 Outside WR/RD: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=cur.
REQ-024 A tick arriving while the FSM is not in IDLE, or coinciding with a pending service, is dropped and sets MISS.
REQ-025 Simultaneous PATTERN write and FSM exit from IDLE: the new value re-arms pending and is issued in the following transaction.
REQ-026 Clearing EN mid-transaction lets the current transaction finish; no further ticks occur.
REQ-027 BUSY=1 whenever the FSM is not in IDLE or pending=1.

Reset
REQ-028 On reset_n low: all registers and cur = 0, FSM = IDLE, pending = 0, prescaler = 0, irq = 0, m_chipselect = 0, m_write_n = 1; no PIO access is issued after reset until a PATTERN write or a tick occurs.

Structure
REQ-029 Package led_seq_pkg holds the FSM state enum, register address constants, MODE codes and STATUS bit indices.
REQ-030 The prescaler is a sub-module, led_tick_gen (inputs en, period; output tick).

Verification
REQ-031 Sequence: PERIOD=3, MODE=10, PATTERN=000001, EN=1 -> PIO writes 000010, 000100, 001000 spaced 4 cycles apart; 100000 is followed by 000001.
REQ-032 Sequence: MODE=11, cur=111111, one tick -> m_writedata=000000 (wrap); MODE=01, PATTERN=101010, two ticks from 000000 -> 101010 then 000000.
REQ-033 VERIFY=1 with the PIO model forcing readback 000000 while writing 000101 -> VERR=1 and irq=1 in the cycle after CHK; writing 1 to STATUS bit1 -> both clear.
REQ-034 PERIOD=0, VERIFY=1 (3-cycle transactions) -> MISS=1 after the first overlapping tick; PIO sees no extra writes.
REQ-035 PATTERN write in the same cycle as a tick -> the written value is issued first and MISS=1.
REQ-036 Assert reset_n during RD -> master outputs idle immediately, all registers read 0 after release, and no PIO strobe follows.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer.
// Holds the sequencer FSM state enum, config register addresses, MODE codes,
// and the bit positions used in the CTRL and STATUS registers.
package led_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWr   = 2'd1,
    StRd   = 2'd2,
    StChk  = 2'd3
  } state_e;

  // Config slave register map
  localparam logic [1:0] AddrCtrl    = 2'd0;
  localparam logic [1:0] AddrPeriod  = 2'd1;
  localparam logic [1:0] AddrPattern = 2'd2;
  localparam logic [1:0] AddrStatus  = 2'd3;

  // CTRL.MODE encodings
  localparam logic [1:0] ModeStatic = 2'b00;
  localparam logic [1:0] ModeBlink  = 2'b01;
  localparam logic [1:0] ModeChase  = 2'b10;
  localparam logic [1:0] ModeCount  = 2'b11;

  // CTRL bit positions
  localparam int unsigned CtrlEnBit     = 0;
  localparam int unsigned CtrlModeLsb   = 1;
  localparam int unsigned CtrlVerifyBit = 3;

  // STATUS bit positions
  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned StatusVerrBit = 1;
  localparam int unsigned StatusMissBit = 2;

endpackage

// File: rtl/led_tick_gen.sv
// Tick prescaler for the LED sequencer.
// Counts 0..period while en is high and pulses tick for one cycle when the
// count reaches the period, then wraps. Held at 0 while en is low.
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : run enable
//   period       : terminal count (0 gives a tick every cycle)
//   tick         : one-cycle pulse on terminal count
module led_tick_gen #(
  parameter int unsigned PRESC_W = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic [PRESC_W-1:0] period,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;
  // Working copy of the period: follows the input while stopped and is only
  // refreshed on a wrap while running, so mid-run writes land on the next wrap.
  logic [PRESC_W-1:0] per_q, per_d;

  always_comb begin
    tick  = en && (cnt_q == per_q);
    cnt_d = cnt_q;
    per_d = per_q;
    if (!en) begin
      cnt_d = '0;
      per_d = period;
    end else if (tick) begin
      cnt_d = '0;
      per_d = period;
    end else begin
      cnt_d = cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      per_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer: generates LED patterns on prescaled ticks and writes them to
// an LED PIO slave, optionally reading each value back to verify it.
//   clk, reset_n      : clock, asynchronous active-low reset
//   cfg_*             : config slave (CTRL, PERIOD, PATTERN, STATUS)
//   m_*               : master port to the LED PIO (zero wait states)
//   irq               : high while STATUS.VERR or STATUS.MISS is set
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned PRESC_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       cfg_address,
  input  logic             cfg_chipselect,
  input  logic             cfg_write_n,
  input  logic [31:0]      cfg_writedata,
  output logic [31:0]      cfg_readdata,
  output logic [1:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [WIDTH-1:0] m_writedata,
  input  logic [WIDTH-1:0] m_readdata,
  output logic             irq
);

  logic               en_q, en_d;
  logic [1:0]         mode_q, mode_d;
  logic               verify_q, verify_d;
  logic [PRESC_W-1:0] period_q, period_d;
  logic [WIDTH-1:0]   pattern_q, pattern_d;
  logic               verr_q, verr_d;
  logic               miss_q, miss_d;
  logic [WIDTH-1:0]   cur_q, cur_d;
  logic               pending_q, pending_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  state_e             state_q, state_d;
  logic               m_chipselect_q, m_chipselect_d;
  logic               m_write_n_q, m_write_n_d;

  logic tick;
  logic wr, wr_ctrl, wr_period, wr_pattern, wr_status;
  logic miss_set, verr_set;
  logic unused_wdata;

  assign unused_wdata = ^cfg_writedata;

  led_tick_gen #(
    .PRESC_W(PRESC_W)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (en_q),
    .period (period_q),
    .tick   (tick)
  );

  function automatic logic [WIDTH-1:0] next_pattern(input logic [1:0]       mode,
                                                     input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] pat);
    logic [WIDTH-1:0] nxt;
    case (mode)
      ModeBlink: nxt = cur ^ pat;
      ModeChase: nxt = (cur == '0) ? WIDTH'(1) : {cur[WIDTH-2:0], cur[WIDTH-1]};
      ModeCount: nxt = cur + WIDTH'(1);
      default:   nxt = pat;
    endcase
    return nxt;
  endfunction

  assign wr         = cfg_chipselect && !cfg_write_n;
  assign wr_ctrl    = wr && (cfg_address == AddrCtrl);
  assign wr_period  = wr && (cfg_address == AddrPeriod);
  assign wr_pattern = wr && (cfg_address == AddrPattern);
  assign wr_status  = wr && (cfg_address == AddrStatus);

  always_comb begin
    en_d      = en_q;
    mode_d    = mode_q;
    verify_d  = verify_q;
    period_d  = period_q;
    pattern_d = pattern_q;
    verr_d    = verr_q;
    miss_d    = miss_q;
    cur_d     = cur_q;
    pending_d = pending_q;
    rdata_d   = rdata_q;
    state_d   = state_q;
    miss_set  = 1'b0;
    verr_set  = 1'b0;

    if (wr_ctrl) begin
      en_d     = cfg_writedata[CtrlEnBit];
      mode_d   = cfg_writedata[CtrlModeLsb +: 2];
      verify_d = cfg_writedata[CtrlVerifyBit];
    end
    if (wr_period) period_d = cfg_writedata[PRESC_W-1:0];
    if (wr_pattern) pattern_d = cfg_writedata[WIDTH-1:0];

    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          state_d   = StWr;
          pending_d = 1'b0;
          miss_set  = tick;
        end else if (tick) begin
          // A PATTERN write landing with the tick counts as a pending
          // service: the written value goes out first and the tick is lost.
          if (wr_pattern) begin
            miss_set = 1'b1;
          end else begin
            state_d = StWr;
            cur_d   = next_pattern(mode_q, cur_q, pattern_q);
          end
        end
      end
      StWr: begin
        state_d  = verify_q ? StRd : StIdle;
        miss_set = tick;
      end
      StRd: begin
        rdata_d  = m_readdata;
        state_d  = StChk;
        miss_set = tick;
      end
      StChk: begin
        verr_set = (rdata_q != cur_q);
        state_d  = StIdle;
        miss_set = tick;
      end
    endcase

    // Overrides the FSM: a PATTERN write always (re)arms the next transaction.
    if (wr_pattern) begin
      cur_d     = cfg_writedata[WIDTH-1:0];
      pending_d = 1'b1;
    end

    // Clears first so that a coincident error event is never lost.
    if (wr_status && cfg_writedata[StatusVerrBit]) verr_d = 1'b0;
    if (wr_status && cfg_writedata[StatusMissBit]) miss_d = 1'b0;
    if (verr_set) verr_d = 1'b1;
    if (miss_set) miss_d = 1'b1;

    m_chipselect_d = (state_d == StWr) || (state_d == StRd);
    m_write_n_d    = (state_d != StWr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q           <= 1'b0;
      mode_q         <= ModeStatic;
      verify_q       <= 1'b0;
      period_q       <= '0;
      pattern_q      <= '0;
      verr_q         <= 1'b0;
      miss_q         <= 1'b0;
      cur_q          <= '0;
      pending_q      <= 1'b0;
      rdata_q        <= '0;
      state_q        <= StIdle;
      m_chipselect_q <= 1'b0;
      m_write_n_q    <= 1'b1;
    end else begin
      en_q           <= en_d;
      mode_q         <= mode_d;
      verify_q       <= verify_d;
      period_q       <= period_d;
      pattern_q      <= pattern_d;
      verr_q         <= verr_d;
      miss_q         <= miss_d;
      cur_q          <= cur_d;
      pending_q      <= pending_d;
      rdata_q        <= rdata_d;
      state_q        <= state_d;
      m_chipselect_q <= m_chipselect_d;
      m_write_n_q    <= m_write_n_d;
    end
  end

  assign m_address    = 2'b00;
  assign m_chipselect = m_chipselect_q;
  assign m_write_n    = m_write_n_q;
  assign m_writedata  = cur_q;
  assign irq          = verr_q || miss_q;

  always_comb begin
    cfg_readdata = '0;
    unique case (cfg_address)
      AddrCtrl: begin
        cfg_readdata[CtrlEnBit]         = en_q;
        cfg_readdata[CtrlModeLsb +: 2]  = mode_q;
        cfg_readdata[CtrlVerifyBit]     = verify_q;
      end
      AddrPeriod:  cfg_readdata[PRESC_W-1:0] = period_q;
      AddrPattern: cfg_readdata[WIDTH-1:0]   = pattern_q;
      AddrStatus: begin
        cfg_readdata[StatusBusyBit] = (state_q != StIdle) || pending_q;
        cfg_readdata[StatusVerrBit] = verr_q;
        cfg_readdata[StatusMissBit] = miss_q;
      end
    endcase
  end

endmodule
